// File: rtl/home_inventory_pkg.sv
// Shared constants for the home inventory measurement sequencer:
// FSM encodings, IRQ source indices and core_status bit positions.
package home_inventory_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_REQ    = 3'd2,
        S_STORE  = 3'd3,
        S_WAIT   = 3'd4
    } state_e;

    localparam int NUM_IRQ     = 3;
    localparam int IRQ_DONE    = 0;
    localparam int IRQ_TIMEOUT = 1;
    localparam int IRQ_OVERRUN = 2;

    localparam int ST_BUSY     = 0;
    localparam int ST_PEND_LSB = 1;
    localparam int ST_DONE     = 4;
    localparam int ST_CH_LSB   = 5;

endpackage

// File: rtl/home_inventory_next_ch.sv
// Combinational next-set-bit finder: lowest set mask bit (first=1) or the
// lowest set bit strictly above cur (first=0).
module home_inventory_next_ch #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              first,
    output logic [CH_W-1:0]   ch,
    output logic              found
);

    always_comb begin
        ch    = '0;
        found = 1'b0;
        // Descending scan so the lowest qualifying bit is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                ch    = CH_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/home_inventory_seq.sv
// Measurement sequencer: sweeps enabled load-cell channels through the ADC port.
// Define HOME_INV_SEQ_PERIODIC_EN to enable the auto-repeat WAIT state.
module home_inventory_seq
    import home_inventory_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 3,
    parameter int DATA_W      = 24,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int PERIOD_W    = 16
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                ctrl_enable,
    input  logic                ctrl_start,
    input  logic [2:0]          irq_en,
    input  logic [2:0]          irq_clr_i,
    input  logic [NUM_CH-1:0]   ch_mask_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                adc_req_o,
    output logic [CH_W-1:0]     adc_ch_o,
    input  logic                adc_ack_i,
    input  logic [DATA_W-1:0]   adc_data_i,
    output logic                res_we_o,
    output logic [CH_W-1:0]     res_ch_o,
    output logic [DATA_W-1:0]   res_data_o,
    output logic [7:0]          core_status,
    output logic                irq_o
);

    localparam int CNT_A = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_B = $clog2(SETTLE_CYC + 1);
    localparam int CNT_C = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int CNT_W = (CNT_C > PERIOD_W) ? CNT_C : PERIOD_W;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                res_we_q, res_we_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [NUM_IRQ-1:0]  pend_q, pend_d, pend_set;
    logic                done_q, done_d;
    logic                irq_q, irq_d;
    logic                busy, sweep_end;
    logic [CH_W-1:0]     nxt_ch;
    logic                nxt_found;

`ifndef HOME_INV_SEQ_PERIODIC_EN
    logic unused_period;
    assign unused_period = ^period_i;
`endif

    home_inventory_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_next_ch (
        .mask  (mask_q),
        .cur   (ch_q),
        .first (state_q == S_SETTLE),
        .ch    (nxt_ch),
        .found (nxt_found)
    );

    assign busy = (state_q == S_SETTLE) || (state_q == S_REQ) || (state_q == S_STORE);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        res_we_d   = 1'b0;
        res_ch_d   = res_ch_q;
        res_data_d = res_data_q;
        done_d     = done_q;
        pend_set   = '0;
        sweep_end  = 1'b0;

        if (ctrl_start && busy) pend_set[IRQ_OVERRUN] = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (ctrl_start && ctrl_enable) begin
                    if (|ch_mask_i) begin
                        mask_d  = ch_mask_i;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        state_d = S_SETTLE;
                    end else begin
                        pend_set[IRQ_DONE] = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (!ctrl_enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d = '0;
                    if (nxt_found) begin
                        ch_d    = nxt_ch;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        sweep_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ: begin
                // An ack always completes its result write, even while aborting.
                if (adc_ack_i) begin
                    req_d      = 1'b0;
                    res_we_d   = 1'b1;
                    res_ch_d   = ch_q;
                    res_data_d = adc_data_i;
                    state_d    = ctrl_enable ? S_STORE : S_IDLE;
                end else if (!ctrl_enable) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    req_d                 = 1'b0;
                    pend_set[IRQ_TIMEOUT] = 1'b1;
                    state_d               = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STORE: begin
                if (!ctrl_enable) begin
                    state_d = S_IDLE;
                end else if (nxt_found) begin
                    ch_d    = nxt_ch;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else begin
                    sweep_end = 1'b1;
                end
            end
`ifdef HOME_INV_SEQ_PERIODIC_EN
            S_WAIT: begin
                if (!ctrl_enable) begin
                    state_d = S_IDLE;
                end else if (ctrl_start || (cnt_q == CNT_W'(period_i) - CNT_W'(1))) begin
                    if (ctrl_start) done_d = 1'b0;
                    mask_d  = ch_mask_i;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (sweep_end) begin
            pend_set[IRQ_DONE] = 1'b1;
            done_d             = 1'b1;
            state_d            = S_IDLE;
`ifdef HOME_INV_SEQ_PERIODIC_EN
            if (period_i != '0) begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
`endif
        end

        // New events beat a simultaneous write-1-to-clear.
        pend_d = (pend_q & ~irq_clr_i) | pend_set;
        irq_d  = |(pend_q & irq_en);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            ch_q       <= '0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            res_we_q   <= 1'b0;
            res_ch_q   <= '0;
            res_data_q <= '0;
            pend_q     <= '0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            res_we_q   <= res_we_d;
            res_ch_q   <= res_ch_d;
            res_data_q <= res_data_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        core_status                         = '0;
        core_status[ST_BUSY]                = busy;
        core_status[ST_PEND_LSB +: NUM_IRQ] = pend_q;
        core_status[ST_DONE]                = done_q;
        core_status[ST_CH_LSB +: CH_W]      = ch_q;
    end

    assign adc_req_o  = req_q;
    assign adc_ch_o   = ch_q;
    assign res_we_o   = res_we_q;
    assign res_ch_o   = res_ch_q;
    assign res_data_o = res_data_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_home_inventory_seq.sv
// Scoreboard bench for home_inventory_seq: directed sweeps, a stub ADC, and a
// monitor that checks every request channel and result write against queues.
module tb_home_inventory_seq;

    localparam int SETTLE = 16;
    localparam int TMO    = 1024;
    localparam int PERIOD = 100;

    logic        clk, rst_n;
    logic        ctrl_enable, ctrl_start;
    logic [2:0]  irq_en, irq_clr;
    logic [3:0]  ch_mask;
    logic [15:0] period;
    logic        adc_req, adc_ack;
    logic [2:0]  adc_ch;
    logic [23:0] adc_data;
    logic        res_we;
    logic [2:0]  res_ch;
    logic [23:0] res_data;
    logic [7:0]  status;
    logic        irq;

    home_inventory_seq dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .ctrl_enable (ctrl_enable),
        .ctrl_start  (ctrl_start),
        .irq_en      (irq_en),
        .irq_clr_i   (irq_clr),
        .ch_mask_i   (ch_mask),
        .period_i    (period),
        .adc_req_o   (adc_req),
        .adc_ch_o    (adc_ch),
        .adc_ack_i   (adc_ack),
        .adc_data_i  (adc_data),
        .res_we_o    (res_we),
        .res_ch_o    (res_ch),
        .res_data_o  (res_data),
        .core_status (status),
        .irq_o       (irq)
    );

    typedef struct {
        logic [2:0]  ch;
        logic [23:0] data;
    } res_t;

    logic [23:0] smp [8] = '{24'h1A0011, 24'h2B0022, 24'h3C0033, 24'h4D0044,
                             24'h5E0055, 24'h6F0066, 24'h700077, 24'h810088};

    res_t       exp_res [$];
    logic [2:0] exp_req [$];
    int checks = 0, errors = 0;
    int cyc = 0, res_cnt = 0, req_hi = 0, req_rises = 0;
    bit ack_en = 1'b1;
    logic req_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (status[0] && n < budget) begin tick(); n++; end
        check({name, "_idle"}, 32'(status[0]), 32'd0);
    endtask

    task automatic wait_req(input string name, input int budget, output int c);
        int n = 0;
        while (!adc_req && n < budget) begin tick(); n++; end
        check({name, "_req_seen"}, 32'(adc_req), 32'd1);
        c = cyc;
    endtask

    task automatic push_sweep(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                exp_req.push_back(3'(i));
                exp_res.push_back('{ch: 3'(i), data: smp[i]});
            end
        end
    endtask

    // Stub ADC: acks on the third cycle a request has been visible.
    initial begin
        int w = 0;
        adc_ack  = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_req && ack_en && !adc_ack) begin
                if (w == 2) begin
                    adc_ack  = 1'b1;
                    adc_data = smp[adc_ch];
                end else begin
                    w++;
                end
            end else begin
                adc_ack = 1'b0;
                w       = 0;
            end
        end
    end

    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (adc_req && !req_prev) begin
                req_rises++;
                if (exp_req.size() == 0) check("unexpected_req", 32'(adc_req), 32'd0);
                else check("req_ch", 32'(adc_ch), 32'(exp_req.pop_front()));
            end
            if (adc_req) req_hi++;
            if (res_we) begin
                res_cnt++;
                if (exp_res.size() == 0) begin
                    check("unexpected_res", 32'(res_we), 32'd0);
                end else begin
                    e = exp_res.pop_front();
                    check("res_ch", 32'(res_ch), 32'(e.ch));
                    check("res_data", 32'(res_data), 32'(e.data));
                end
            end
            req_prev = adc_req;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c, base, rises0;
        rst_n = 1'b0; ctrl_enable = 1'b0; ctrl_start = 1'b0;
        irq_en = 3'b000; irq_clr = 3'b000; ch_mask = '0; period = '0;
        tick(3);
        check("rst_req", 32'(adc_req), 32'd0);
        check("rst_we", 32'(res_we), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1; ctrl_enable = 1'b1; irq_en = 3'b001;
        tick();

        // Sweep channels 0, 1, 3
        ch_mask = 4'b1011; push_sweep(4'b1011); base = res_cnt;
        pulse_start(); t0 = cyc;
        check("t1_busy", 32'(status[0]), 32'd1);
        wait_req("t1", 100, c);
        check("t1_settle_lat", 32'(c - t0), 32'(SETTLE));
        wait_idle("t1", 200);
        tick(2);
        check("t1_writes", 32'(res_cnt - base), 32'd3);
        check("t1_pend", 32'(status[3:1]), 32'b001);
        check("t1_done_sticky", 32'(status[4]), 32'd1);
        check("t1_irq", 32'(irq), 32'd1);
        irq_clr = 3'b111; tick(); irq_clr = 3'b000; tick(2);
        check("clr_pend", 32'(status[3:1]), 32'd0);
        check("clr_irq", 32'(irq), 32'd0);

        // No ack on channel 2: timeout after exactly TMO request cycles
        ack_en = 1'b0; ch_mask = 4'b0100; exp_req.push_back(3'd2);
        base = res_cnt; req_hi = 0;
        pulse_start();
        wait_idle("t2", TMO + 100);
        tick(2);
        check("t2_req_cycles", 32'(req_hi), 32'(TMO));
        check("t2_writes", 32'(res_cnt - base), 32'd0);
        check("t2_pend", 32'(status[3:1]), 32'b010);
        ack_en = 1'b1;
        irq_clr = 3'b111; tick(); irq_clr = 3'b000; tick();

        // Second start mid-sweep flags overrun without disturbing the sweep
        ch_mask = 4'b1011; push_sweep(4'b1011); base = res_cnt;
        pulse_start(); tick(4); pulse_start();
        check("t3_ovr_pend", 32'(status[3]), 32'd1);
        check("t3_still_busy", 32'(status[0]), 32'd1);
        wait_idle("t3", 200);
        tick(2);
        check("t3_writes", 32'(res_cnt - base), 32'd3);
        check("t3_pend", 32'(status[3:1]), 32'b101);
        irq_clr = 3'b111; tick(); irq_clr = 3'b000; tick(2);

        // Enable dropped while a request is outstanding
        ack_en = 1'b0; ch_mask = 4'b0001; exp_req.push_back(3'd0);
        pulse_start();
        wait_req("t4", 100, c);
        tick(3);
        ctrl_enable = 1'b0; tick();
        check("t4_req_drop", 32'(adc_req), 32'd0);
        check("t4_idle", 32'(status[0]), 32'd0);
        tick(2);
        check("t4_pend", 32'(status[3:1]), 32'd0);
        check("t4_irq", 32'(irq), 32'd0);
        ctrl_enable = 1'b1; ack_en = 1'b1;

        // Clear colliding with DONE set: set wins; later clear drops irq a cycle after
        ch_mask = 4'b0001; push_sweep(4'b0001);
        pulse_start();
        c = 0;
        while (!res_we && c < 100) begin tick(); c++; end
        check("t5_we_seen", 32'(res_we), 32'd1);
        irq_clr = 3'b001; tick(); irq_clr = 3'b000;
        check("t5_set_wins", 32'(status[1]), 32'd1);
        check("t5_irq_lag", 32'(irq), 32'd0);
        tick();
        check("t5_irq_rise", 32'(irq), 32'd1);
        irq_clr = 3'b001; tick(); irq_clr = 3'b000;
        check("t5_pend_clr", 32'(status[1]), 32'd0);
        check("t5_irq_hold", 32'(irq), 32'd1);
        tick();
        check("t5_irq_fall", 32'(irq), 32'd0);

        // Auto-repeat
        period = 16'(PERIOD); ch_mask = 4'b0001; push_sweep(4'b0001);
        rises0 = req_rises;
        pulse_start();
`ifdef HOME_INV_SEQ_PERIODIC_EN
        push_sweep(4'b0001);
        c = 0;
        while (!status[1] && c < 200) begin tick(); c++; end
        check("t6_done_seen", 32'(status[1]), 32'd1);
        t0 = cyc;
        check("t6_wait_not_busy", 32'(status[0]), 32'd0);
        wait_req("t6", 400, c);
        // first cycle of the new request vs the edge that set DONE
        check("t6_restart_lat", 32'(c - t0), 32'(PERIOD + SETTLE));
        wait_idle("t6", 200);
        ctrl_enable = 1'b0; tick(2); ctrl_enable = 1'b1;
        check("t6_rises", 32'(req_rises - rises0), 32'd2);
`else
        wait_idle("t6", 200);
        tick(2 * PERIOD);
        check("t6_no_repeat", 32'(req_rises - rises0), 32'd1);
        check("t6_idle_req", 32'(adc_req), 32'd0);
`endif
        tick(2);
        check("end_req_q", 32'(exp_req.size()), 32'd0);
        check("end_res_q", 32'(exp_res.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
